// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the MEM stage.
// Word-crossing accesses run as two beats through a small IDLE/SPLIT FSM.
package data_memory_pkg;
    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } load_type;
endpackage

module data_memory
    import data_memory_pkg::*;
#(
    parameter int    MEM_BITS  = 16,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  load_type    req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_split
);

    localparam int IDX_BITS = MEM_BITS - 2;
    localparam int ENTRIES  = 2 ** IDX_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] mem [ENTRIES];

    logic                accept;
    logic [IDX_BITS-1:0] req_index;
    logic [1:0]          req_off;
    logic                unused_addr;

    // Beat-1 context kept for the second half of a split access.
    load_type            lat_size;
    logic                lat_unsigned;
    logic                lat_write;
    logic [31:0]         lat_wdata;
    logic [IDX_BITS-1:0] lat_index;
    logic [1:0]          lat_off;
    logic [31:0]         lat_lo;

    load_type            cur_size;
    logic                cur_unsigned;
    logic [31:0]         cur_wdata;
    logic [1:0]          cur_off;
    logic [IDX_BITS-1:0] access_index;
    logic [31:0]         read_word;
    logic [7:0]          lane_mask;
    logic [63:0]         wdata_shifted;
    logic [63:0]         read_pair;
    logic [63:0]         read_shifted;

    logic                mem_we;
    logic [3:0]          mem_be;
    logic [31:0]         mem_wdata;
    logic                load_done;
    logic                load_split;
    logic [31:0]         load_value;

    function automatic logic [3:0] size_mask(input load_type size);
        case (size)
            HALFWORD: return 4'b0011;
            WORD:     return 4'b1111;
            default:  return 4'b0001;
        endcase
    endfunction

    function automatic logic crosses_word(input load_type size, input logic [1:0] off);
        return (size == HALFWORD && off == 2'd3) || (size == WORD && off != 2'd0);
    endfunction

    function automatic logic [31:0] extend(input load_type size, input logic uns,
                                           input logic [31:0] raw);
        case (size)
            BYTE:     return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            HALFWORD: return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

    assign req_ready   = reset_n && (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign req_index   = req_addr[MEM_BITS-1:2];
    assign req_off     = req_addr[1:0];
    assign unused_addr = ^req_addr[31:MEM_BITS];

    assign cur_size     = (state == IDLE) ? req_size     : lat_size;
    assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
    assign cur_off      = (state == IDLE) ? req_off      : lat_off;

    // Beat 2 always targets the following entry; the index wraps naturally at the top.
    assign access_index = (state == IDLE) ? req_index
                                          : lat_index + {{(IDX_BITS-1){1'b0}}, 1'b1};
    assign read_word    = mem[access_index];

    // Low nibble of the mask / low word of the data belong to beat 1, the rest to beat 2.
    assign lane_mask     = {4'b0000, size_mask(cur_size)} << cur_off;
    assign wdata_shifted = {32'h0, cur_wdata} << {cur_off, 3'b000};
    assign read_pair     = (state == SPLIT) ? {read_word, lat_lo} : {32'h0, read_word};
    assign read_shifted  = read_pair >> {cur_off, 3'b000};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'h0;
        load_done  = 1'b0;
        load_split = 1'b0;
        load_value = extend(cur_size, cur_unsigned, read_shifted[31:0]);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        mem_we    = 1'b1;
                        mem_be    = lane_mask[3:0];
                        mem_wdata = wdata_shifted[31:0];
                    end else if (!crosses_word(req_size, req_off)) begin
                        load_done = 1'b1;
                    end
                    if (crosses_word(req_size, req_off)) begin
                        next_state = SPLIT;
                    end
                end
            end
            SPLIT: begin
                next_state = IDLE;
                if (lat_write) begin
                    mem_we    = 1'b1;
                    mem_be    = lane_mask[7:4];
                    mem_wdata = wdata_shifted[63:32];
                end else begin
                    load_done  = 1'b1;
                    load_split = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Contents are never reset; writes are merely suppressed while reset_n is low.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) begin
                    mem[access_index][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_write    <= req_write;
            lat_wdata    <= req_wdata;
            lat_index    <= req_index;
            lat_off      <= req_off;
            lat_lo       <= read_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_split <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= load_done;
            rsp_split <= load_split;
            if (load_done) begin
                rsp_rdata <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: aligned, sub-word, split,
// wrap-around, back-to-back and reset-during-split scenarios.
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    load_type    req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_split;

    int total = 0;
    int bad   = 0;

    data_memory #(.MEM_BITS(16), .INIT_FILE("")) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_split    (rsp_split)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic issue_load(input logic [31:0] addr, input load_type size, input logic uns,
                              output logic [31:0] data, output logic split,
                              output logic seen, output int lat);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        data  = rsp_rdata;
        split = rsp_split;
        seen  = rsp_valid;
        @(posedge clk); #1;
    endtask

    task automatic issue_store(input logic [31:0] addr, input load_type size,
                               input logic [31:0] wdata, output int busy, output logic saw_rsp);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        busy      = 0;
        saw_rsp   = rsp_valid;
        while (!req_ready && busy < 5) begin
            busy++;
            @(posedge clk); #1;
            saw_rsp = saw_rsp | rsp_valid;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_split !== 1'b0) begin bad++; $display("FAIL reset_rsp_split: got %b want 0", rsp_split); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 00000000", rsp_rdata); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned_word();
        logic [31:0] d; logic s, v; int lat, busy; logic saw;
        issue_store(32'h100, WORD, 32'h8899AABB, busy, saw);
        total++; if (busy !== 0) begin bad++; $display("FAIL aligned_store_busy: got %0d want 0", busy); end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL aligned_store_rsp: got %b want 0", saw); end
        issue_load(32'h100, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h8899AABB) begin bad++; $display("FAIL aligned_load_data: got %h want 8899aabb", d); end
        total++; if (lat !== 1) begin bad++; $display("FAIL aligned_load_latency: got %0d want 1", lat); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL aligned_load_split: got %b want 0", s); end
    endtask

    task automatic test_subword_loads();
        logic [31:0] d; logic s, v; int lat;
        issue_load(32'h100, BYTE, 1'b0, d, s, v, lat);
        total++; if (d !== 32'hFFFFFFBB) begin bad++; $display("FAIL byte_signed: got %h want ffffffbb", d); end
        issue_load(32'h103, BYTE, 1'b1, d, s, v, lat);
        total++; if (d !== 32'h00000088) begin bad++; $display("FAIL byte_unsigned: got %h want 00000088", d); end
        issue_load(32'h102, HALFWORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'hFFFF8899) begin bad++; $display("FAIL half_signed_off2: got %h want ffff8899", d); end
        total++; if (lat !== 1 || s !== 1'b0) begin bad++; $display("FAIL half_off2_not_split: got lat=%0d split=%b want lat=1 split=0", lat, s); end
        issue_load(32'h101, HALFWORD, 1'b1, d, s, v, lat);
        total++; if (d !== 32'h000099AA) begin bad++; $display("FAIL half_unsigned_off1: got %h want 000099aa", d); end
    endtask

    task automatic test_byte_store();
        logic [31:0] d; logic s, v; int lat, busy; logic saw;
        issue_store(32'h104, WORD, 32'h0, busy, saw);
        issue_store(32'h105, BYTE, 32'hFFFFFF5A, busy, saw);
        issue_load(32'h104, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h00005A00) begin bad++; $display("FAIL byte_store_lane: got %h want 00005a00", d); end
        issue_load(32'h100, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h8899AABB) begin bad++; $display("FAIL byte_store_neighbour: got %h want 8899aabb", d); end
    endtask

    task automatic test_split_store();
        logic [31:0] d; logic s, v; int lat, busy; logic saw;
        issue_store(32'h104, WORD, 32'h0, busy, saw);
        issue_store(32'h108, WORD, 32'h0, busy, saw);
        issue_store(32'h107, WORD, 32'h11223344, busy, saw);
        total++; if (busy !== 1) begin bad++; $display("FAIL split_store_busy: got %0d want 1", busy); end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL split_store_rsp: got %b want 0", saw); end
        issue_load(32'h104, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h44000000) begin bad++; $display("FAIL split_low_word: got %h want 44000000", d); end
        issue_load(32'h108, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h00112233) begin bad++; $display("FAIL split_high_word: got %h want 00112233", d); end
        issue_load(32'h107, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h11223344) begin bad++; $display("FAIL split_load_data: got %h want 11223344", d); end
        total++; if (lat !== 2) begin bad++; $display("FAIL split_load_latency: got %0d want 2", lat); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL split_load_flag: got %b want 1", s); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic s, v; int lat, busy; logic saw;
        issue_store(32'hFFFFFFFF, HALFWORD, 32'h0000BEEF, busy, saw);
        issue_load(32'h0000FFFF, BYTE, 1'b1, d, s, v, lat);
        total++; if (d !== 32'h000000EF) begin bad++; $display("FAIL wrap_top_byte: got %h want 000000ef", d); end
        issue_load(32'h00000000, BYTE, 1'b1, d, s, v, lat);
        total++; if (d !== 32'h000000BE) begin bad++; $display("FAIL wrap_bottom_byte: got %h want 000000be", d); end
        issue_load(32'h0000FFFF, HALFWORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'hFFFFBEEF || s !== 1'b1) begin bad++; $display("FAIL wrap_half_load: got %h split=%b want ffffbeef split=1", d, s); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_size = WORD; req_unsigned = 1'b0;
        req_addr  = 32'h104;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h44000000) begin bad++; $display("FAIL b2b_first: got v=%b %h want v=1 44000000", rsp_valid, rsp_rdata); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        req_addr = 32'h108;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00112233) begin bad++; $display("FAIL b2b_second: got v=%b %h want v=1 00112233", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end: got %b want 0", rsp_valid); end
    endtask

    task automatic test_store_then_load();
        req_valid = 1'b1; req_write = 1'b1; req_size = BYTE;
        req_addr  = 32'h100; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h00112233) begin bad++; $display("FAIL store_no_rsp: got v=%b %h want v=0 00112233", rsp_valid, rsp_rdata); end
        req_write = 1'b0; req_unsigned = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000077) begin bad++; $display("FAIL store_load_fwd: got v=%b %h want v=1 00000077", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        total++; if (rsp_rdata !== 32'h00000077) begin bad++; $display("FAIL rdata_hold: got %h want 00000077", rsp_rdata); end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] d; logic s, v; int lat, busy; logic saw;
        issue_store(32'h200, WORD, 32'h0, busy, saw);
        issue_store(32'h204, WORD, 32'h0, busy, saw);
        req_valid = 1'b1; req_write = 1'b1; req_size = WORD;
        req_addr  = 32'h201; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midsplit_rsp: got %b want 0", rsp_valid); end
        reset_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midsplit_idle: got %b want 1", req_ready); end
        issue_load(32'h200, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'hFEF00D00) begin bad++; $display("FAIL midsplit_beat1: got %h want fef00d00", d); end
        issue_load(32'h204, WORD, 1'b0, d, s, v, lat);
        total++; if (d !== 32'h00000000 || v !== 1'b1) begin bad++; $display("FAIL midsplit_beat2: got %h v=%b want 00000000 v=1", d, v); end
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_size     = BYTE;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_aligned_word();
        test_subword_loads();
        test_byte_store();
        test_split_store();
        test_wrap();
        test_back_to_back();
        test_store_then_load();
        test_reset_mid_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
